// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI read arbiter: FSM state encoding plus
// AXI response and burst-type codes.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    localparam logic [1:0] OKAY        = 2'b00;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner select. Round-robin on last_served when AXI_RD_ARB_RR_EN
// is defined, otherwise fixed priority with m0 winning ties.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] gnt
);

`ifdef AXI_RD_ARB_RR_EN
    // last_served=1 means m1 finished most recently, so m0 takes a tie.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_served ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused_last_served;

    assign w_unused_last_served = last_served;
    assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`endif

endmodule

// File: rtl/axi_rd_arb.sv
// Two-master AXI read arbiter onto one memory slave: IDLE/ADDR/DATA FSM,
// burst length tracked by an 8-bit beat counter. AXI_RD_ARB_RR_EN selects round-robin.
module axi_rd_arb
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m0_ar_addr,
    input  logic [7:0]            m0_ar_len,
    input  logic [2:0]            m0_ar_size,
    input  logic [1:0]            m0_ar_burst,
    input  logic                  m0_ar_valid,
    output logic                  m0_ar_ready,
    output logic [DATA_WIDTH-1:0] m0_r_data,
    output logic [1:0]            m0_r_resp,
    output logic                  m0_r_last,
    output logic                  m0_r_valid,
    input  logic                  m0_r_ready,
    input  logic [ADDR_WIDTH-1:0] m1_ar_addr,
    input  logic [7:0]            m1_ar_len,
    input  logic [2:0]            m1_ar_size,
    input  logic [1:0]            m1_ar_burst,
    input  logic                  m1_ar_valid,
    output logic                  m1_ar_ready,
    output logic [DATA_WIDTH-1:0] m1_r_data,
    output logic [1:0]            m1_r_resp,
    output logic                  m1_r_last,
    output logic                  m1_r_valid,
    input  logic                  m1_r_ready,
    output logic [ADDR_WIDTH-1:0] s_ar_addr,
    output logic [7:0]            s_ar_len,
    output logic [2:0]            s_ar_size,
    output logic [1:0]            s_ar_burst,
    output logic                  s_ar_valid,
    input  logic                  s_ar_ready,
    input  logic [DATA_WIDTH-1:0] s_r_data,
    input  logic [1:0]            s_r_resp,
    input  logic                  s_r_last,
    input  logic                  s_r_valid,
    output logic                  s_r_ready,
    output logic [1:0]            grant,
    output logic                  busy
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [1:0]  r_grant;
    logic [7:0]  r_cnt;
    logic [1:0]  w_req;
    logic [1:0]  w_win;
    logic        w_last_served;
    logic        w_sel_m1;
    logic        w_ar_hs;
    logic        w_r_hs;

    assign w_req    = {m1_ar_valid, m0_ar_valid};
    assign w_sel_m1 = r_grant[1];
    assign w_ar_hs  = s_ar_valid && s_ar_ready;
    assign w_r_hs   = s_r_valid && s_r_ready;
    assign grant    = r_grant;
    assign busy     = (r_state != ST_IDLE);

`ifdef AXI_RD_ARB_RR_EN
    logic r_last_served;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_served <= 1'b1;
        end else if (r_state == ST_DATA && w_r_hs && r_cnt == 8'd0) begin
            r_last_served <= r_grant[1];
        end
    end

    assign w_last_served = r_last_served;
`else
    assign w_last_served = 1'b1;
`endif

    rr_arb2 u_rr_arb2 (
        .req         (w_req),
        .last_served (w_last_served),
        .gnt         (w_win)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: if (|w_req) r_grant <= w_win;
                ST_ADDR: if (w_ar_hs) r_cnt <= w_sel_m1 ? m1_ar_len : m0_ar_len;
                ST_DATA: begin
                    // The counter alone ends the burst; s_r_last is only forwarded.
                    if (w_r_hs) begin
                        if (r_cnt == 8'd0) r_grant <= 2'b00;
                        else               r_cnt   <= r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_req) w_state_nxt = ST_ADDR;
            ST_ADDR: if (w_ar_hs) w_state_nxt = ST_DATA;
            ST_DATA: if (w_r_hs && r_cnt == 8'd0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ar_addr   = w_sel_m1 ? m1_ar_addr  : m0_ar_addr;
        s_ar_len    = w_sel_m1 ? m1_ar_len   : m0_ar_len;
        s_ar_size   = w_sel_m1 ? m1_ar_size  : m0_ar_size;
        s_ar_burst  = w_sel_m1 ? m1_ar_burst : m0_ar_burst;
        s_ar_valid  = 1'b0;
        m0_ar_ready = 1'b0;
        m1_ar_ready = 1'b0;
        s_r_ready   = 1'b0;
        m0_r_valid  = 1'b0;
        m1_r_valid  = 1'b0;
        m0_r_data   = s_r_data;
        m1_r_data   = s_r_data;
        m0_r_resp   = s_r_resp;
        m1_r_resp   = s_r_resp;
        m0_r_last   = s_r_last;
        m1_r_last   = s_r_last;
        case (r_state)
            ST_ADDR: begin
                s_ar_valid  = w_sel_m1 ? m1_ar_valid : m0_ar_valid;
                m0_ar_ready = !w_sel_m1 && s_ar_ready;
                m1_ar_ready =  w_sel_m1 && s_ar_ready;
            end
            ST_DATA: begin
                s_r_ready  = w_sel_m1 ? m1_r_ready : m0_r_ready;
                m0_r_valid = !w_sel_m1 && s_r_valid;
                m1_r_valid =  w_sel_m1 && s_r_valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: a memory-slave model answers bursts, and a
// scoreboard queue holds the beats each master is expected to receive, in order.
module tb_axi_rd_arb;
    import axi_arb_pkg::*;

    typedef struct packed {
        logic        m;
        logic        last;
        logic [1:0]  resp;
        logic [31:0] data;
    } beat_t;

    logic        clk, rst_n;
    logic [7:0]  m0_ar_addr, m1_ar_addr, s_ar_addr;
    logic [7:0]  m0_ar_len, m1_ar_len, s_ar_len;
    logic [2:0]  m0_ar_size, m1_ar_size, s_ar_size;
    logic [1:0]  m0_ar_burst, m1_ar_burst, s_ar_burst;
    logic        m0_ar_valid, m1_ar_valid, s_ar_valid;
    logic        m0_ar_ready, m1_ar_ready, s_ar_ready;
    logic [31:0] m0_r_data, m1_r_data, s_r_data;
    logic [1:0]  m0_r_resp, m1_r_resp, s_r_resp;
    logic        m0_r_last, m1_r_last, s_r_last;
    logic        m0_r_valid, m1_r_valid, s_r_valid;
    logic        m0_r_ready, m1_r_ready, s_r_ready;
    logic [1:0]  grant;
    logic        busy;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats_m0 = 0;
    int    beats_m1 = 0;
    beat_t exp_q[$];

    axi_rd_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_ar_addr(m0_ar_addr), .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size),
        .m0_ar_burst(m0_ar_burst), .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
        .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
        .m1_ar_addr(m1_ar_addr), .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size),
        .m1_ar_burst(m1_ar_burst), .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
        .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
        .s_ar_burst(s_ar_burst), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .grant(grant), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [7:0] a, input int b);
        logic [7:0] bb;
        bb = b[7:0];
        return {8'hD0, a, 8'h5A, bb};
    endfunction

    task automatic expect_burst(input logic m, input logic [7:0] addr, input int len);
        for (int b = 0; b <= len; b++) begin
            exp_q.push_back('{m: m, last: (b == len), resp: OKAY, data: beat_data(addr, b)});
        end
    endtask

    task automatic issue(input logic m, input logic [7:0] addr, input logic [7:0] len);
        if (!m) begin
            m0_ar_addr = addr; m0_ar_len = len; m0_ar_valid = 1'b1;
        end else begin
            m1_ar_addr = addr; m1_ar_len = len; m1_ar_valid = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((busy || exp_q.size() != 0) && n < budget);
        check({tag, "_done"}, 64'(busy || exp_q.size() != 0), 0);
    endtask

    // Requester model: drops ar_valid once its address handshake completes.
    initial begin
        logic hs0, hs1;
        forever begin
            @(negedge clk);
            hs0 = m0_ar_valid && m0_ar_ready;
            hs1 = m1_ar_valid && m1_ar_ready;
            @(posedge clk); #1;
            if (hs0) m0_ar_valid = 1'b0;
            if (hs1) m1_ar_valid = 1'b0;
        end
    end

    // Memory-slave model: one beat per accepted R handshake, aborted by reset.
    initial begin
        logic       ar_hs, r_hs, rst_seen, active;
        logic [7:0] sl_addr, cap_addr;
        int         sl_len, cap_len, sl_beat;
        active = 1'b0; sl_addr = '0; sl_len = 0; sl_beat = 0;
        s_r_valid = 1'b0; s_r_data = '0; s_r_resp = OKAY; s_r_last = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs    = s_ar_valid && s_ar_ready && rst_n;
            r_hs     = s_r_valid && s_r_ready;
            rst_seen = !rst_n;
            cap_addr = s_ar_addr;
            cap_len  = int'(s_ar_len);
            @(posedge clk); #1;
            if (rst_seen) begin
                active = 1'b0;
            end else begin
                if (r_hs) begin
                    if (sl_beat == sl_len) active = 1'b0;
                    else sl_beat++;
                end
                if (ar_hs) begin
                    active = 1'b1; sl_addr = cap_addr; sl_len = cap_len; sl_beat = 0;
                end
            end
            s_r_valid = active;
            s_r_data  = beat_data(sl_addr, sl_beat);
            s_r_resp  = OKAY;
            s_r_last  = active && (sl_beat == sl_len);
        end
    end

    // Scoreboard monitor: every delivered beat must match the head of the queue.
    always @(negedge clk) begin
        beat_t got;
        check("r_valid_onehot", 64'(m0_r_valid && m1_r_valid), 0);
        if ((m0_r_valid && m0_r_ready) || (m1_r_valid && m1_r_ready)) begin
            got.m    = m1_r_valid;
            got.last = m1_r_valid ? m1_r_last : m0_r_last;
            got.resp = m1_r_valid ? m1_r_resp : m0_r_resp;
            got.data = m1_r_valid ? m1_r_data : m0_r_data;
            if (m1_r_valid) beats_m1++;
            else            beats_m0++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(exp_q.size()), 1);
            end else begin
                check("r_beat", 64'(got), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int base, n;
        rst_n = 1'b0; s_ar_ready = 1'b1;
        m0_ar_addr = '0; m0_ar_len = '0; m0_ar_size = 3'd2; m0_ar_burst = BURST_INCR; m0_ar_valid = 1'b0;
        m1_ar_addr = '0; m1_ar_len = '0; m1_ar_size = 3'd2; m1_ar_burst = BURST_INCR; m1_ar_valid = 1'b0;
        m0_r_ready = 1'b1; m1_r_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_grant", 64'(grant), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_m0_ar_ready", 64'(m0_ar_ready), 0);
        check("rst_m1_ar_ready", 64'(m1_ar_ready), 0);
        check("rst_s_ar_valid", 64'(s_ar_valid), 0);
        check("rst_s_r_ready", 64'(s_r_ready), 0);
        check("rst_r_valid", 64'({m0_r_valid, m1_r_valid}), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic m0 burst, len=3
        base = beats_m0;
        @(posedge clk); #2;
        issue(1'b0, 8'h10, 8'd3);
        expect_burst(1'b0, 8'h10, 3);
        @(negedge clk);
        check("idle_grant_before_reg", 64'(grant), 0);
        check("idle_ar_ready", 64'(m0_ar_ready), 0);
        @(negedge clk);
        check("addr_grant", 64'(grant), 64'(2'b01));
        check("addr_busy", 64'(busy), 1);
        check("addr_s_ar_valid", 64'(s_ar_valid), 1);
        check("addr_s_ar_addr", 64'(s_ar_addr), 64'h10);
        check("addr_s_ar_len", 64'(s_ar_len), 3);
        check("addr_m0_ar_ready", 64'(m0_ar_ready), 1);
        check("addr_m1_ar_ready", 64'(m1_ar_ready), 0);
        wait_done("basic", 20);
        check("basic_beats", 64'(beats_m0 - base), 4);
        check("basic_grant_idle", 64'(grant), 0);

        // Solo m1 single beat (len=0)
        base = beats_m1;
        @(posedge clk); #2;
        issue(1'b1, 8'h18, 8'd0);
        expect_burst(1'b1, 8'h18, 0);
        wait_done("m1_solo", 20);
        check("m1_solo_beats", 64'(beats_m1 - base), 1);

        // Simultaneous requests, twice: m0 first both times
        for (int rep = 0; rep < 2; rep++) begin
            @(posedge clk); #2;
            issue(1'b0, 8'h20, 8'd1);
            issue(1'b1, 8'h30, 8'd1);
            expect_burst(1'b0, 8'h20, 1);
            expect_burst(1'b1, 8'h30, 1);
            @(negedge clk); @(negedge clk);
            check("tie_first_grant", 64'(grant), 64'(2'b01));
            wait_done("tie", 40);
        end

        // Tie, then m0 keeps requesting while m1 waits
        @(posedge clk); #2;
        issue(1'b0, 8'h20, 8'd1);
        issue(1'b1, 8'h30, 8'd1);
        expect_burst(1'b0, 8'h20, 1);
`ifdef AXI_RD_ARB_RR_EN
        expect_burst(1'b1, 8'h30, 1);
        expect_burst(1'b0, 8'h24, 1);
`else
        expect_burst(1'b0, 8'h24, 1);
        expect_burst(1'b1, 8'h30, 1);
`endif
        n = 0;
        do begin @(negedge clk); n++; end while (m0_ar_valid && n < 20);
        check("rereq_wait", 64'(m0_ar_valid), 0);
        @(posedge clk); #2;
        issue(1'b0, 8'h24, 8'd1);
        wait_done("rereq", 60);

        // m1 requests during m0 len=7 burst
        base = beats_m0;
        @(posedge clk); #2;
        issue(1'b0, 8'h40, 8'd7);
        expect_burst(1'b0, 8'h40, 7);
        expect_burst(1'b1, 8'h44, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (m0_ar_valid && n < 20);
        @(posedge clk); #2;
        issue(1'b1, 8'h44, 8'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (grant == 2'b01) check("hold_m1_ar_ready", 64'(m1_ar_ready), 0);
        end while (grant == 2'b01 && n < 30);
        check("hold_idle_gap", 64'(grant), 0);
        @(negedge clk);
        check("hold_m1_granted", 64'(grant), 64'(2'b10));
        wait_done("hold", 20);
        check("hold_m0_beats", 64'(beats_m0 - base), 8);

        // r_ready toggling on m0, len=1
        base = beats_m0;
        @(posedge clk); #2;
        issue(1'b0, 8'h50, 8'd1);
        expect_burst(1'b0, 8'h50, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!m0_ar_ready && n < 20);
        check("toggle_ar_seen", 64'(m0_ar_ready), 1);
        n = 0;
        forever begin
            @(posedge clk); #1 m0_r_ready = !m0_r_ready;
            @(negedge clk);
            n++;
            if (!busy || n >= 20) break;
            check("toggle_s_r_ready", 64'(s_r_ready), 64'(m0_r_ready));
        end
        m0_r_ready = 1'b1;
        check("toggle_busy_end", 64'(busy), 0);
        check("toggle_beats", 64'(beats_m0 - base), 2);

        // Reset mid-burst
        base = beats_m0;
        @(posedge clk); #2;
        issue(1'b0, 8'h60, 8'd3);
        expect_burst(1'b0, 8'h60, 3);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (beats_m0 - base < 2 && n < 20);
        check("abort_reach_beat2", 64'(beats_m0 - base), 2);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 0);
        check("abort_grant", 64'(grant), 0);
        check("abort_r_valid", 64'(m0_r_valid), 0);
        check("abort_s_r_ready", 64'(s_r_ready), 0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        base = beats_m0;
        @(posedge clk); #2;
        issue(1'b0, 8'h70, 8'd0);
        expect_burst(1'b0, 8'h70, 0);
        wait_done("post_reset", 20);
        check("post_reset_beats", 64'(beats_m0 - base), 1);

        // Longest burst, len=255 on m1
        base = beats_m1;
        @(posedge clk); #2;
        issue(1'b1, 8'h80, 8'd255);
        expect_burst(1'b1, 8'h80, 255);
        wait_done("len255", 400);
        check("len255_beats", 64'(beats_m1 - base), 256);
        check("final_queue_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: AR address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: R data width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports m0_ar_addr/m1_ar_addr, input, ADDR_WIDTH: requester read addresses.
REQ-006 SHALL have ports m0_ar_len/m1_ar_len (input, 8), m0_ar_size/m1_ar_size (input, 3), m0_ar_burst/m1_ar_burst (input, 2): requester burst attributes.
REQ-007 SHALL have ports m0_ar_valid/m1_ar_valid (input, 1) and m0_ar_ready/m1_ar_ready (output, 1): requester AR handshake.
REQ-008 SHALL have ports m0_r_data/m1_r_data (output, DATA_WIDTH) and m0_r_resp/m1_r_resp (output, 2): returned read data and response.
REQ-009 SHALL have ports m0_r_last/m1_r_last, m0_r_valid/m1_r_valid (output, 1) and m0_r_ready/m1_r_ready (input, 1): requester R handshake.
REQ-010 SHALL have ports s_ar_addr/len/size/burst/valid (output) and s_ar_ready (input): AR toward the shared memory slave, same widths as the requester side.
REQ-011 SHALL have ports s_r_data/resp/last/valid (input) and s_r_ready (output): R from the shared memory slave.
REQ-012 SHALL have port grant, output, 2: one-hot owner, 2'b00 when idle.
REQ-013 SHALL have port busy, output, 1: high in ADDR or DATA.

Function
REQ-014 SHALL implement the states IDLE, ADDR and DATA.
REQ-015 IDLE: on any mX_ar_valid, the arbiter SHALL register the winner into grant and go to ADDR next cycle; all readies and valids are 0 in IDLE.
REQ-016 ADDR: the granted master's AR SHALL be passed combinationally to s_ar_*, and the loser's ar_ready SHALL be 0.
REQ-017 On the s_ar_valid&&s_ar_ready handshake, the arbiter SHALL latch ar_len into the 8-bit beat counter and go to DATA.
REQ-018 DATA: s_r_* SHALL be routed to the granted master, s_r_ready SHALL equal the granted mX_r_ready, and the loser's r_valid SHALL be 0.
REQ-019 Each R handshake in DATA SHALL decrement the counter; the handshake with counter==0 SHALL return the state to IDLE, clear grant and record last_served.
REQ-020 Termination SHALL be by the counter only; s_r_last SHALL be forwarded unchanged and never used for control.
REQ-021 A request arriving mid-burst SHALL be held with ar_ready=0; no grant change SHALL occur outside IDLE.
REQ-022 If ar_valid drops in ADDR, the arbiter SHALL stay in ADDR with the grant unchanged.
REQ-023 Worst case, the arbiter SHALL add one idle cycle between bursts: last beat -> IDLE -> re-arbitrate.
REQ-024 ar_len=0 SHALL give a single-beat burst; ar_len=255 SHALL give 256 beats with no counter wrap.

Reset
REQ-025 While rst_n=0, state SHALL be IDLE, grant 2'b00, counter 0, last_served=m1 so that m0 wins first.
REQ-026 While rst_n=0, all ar_ready, r_valid, s_ar_valid, s_r_ready and busy outputs SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abort immediately with no completion beat.

Configuration
REQ-028 With AXI_RD_ARB_RR_EN defined, simultaneous requests SHALL be granted to the master not in last_served (round-robin).
REQ-029 Without AXI_RD_ARB_RR_EN, m0 SHALL always win simultaneous requests (fixed priority), and last_served SHALL be unused.

Structure
REQ-030 The package axi_arb_pkg SHALL hold the state encoding, the OKAY=2'b00 constant and the burst type constants.
REQ-031 The winner selection SHALL be a sub-module rr_arb2: inputs req[1:0], last_served; output gnt[1:0].

Verification
REQ-032 Reset, then m0 ar_valid addr=0x10 len=3: grant=01 after 1 cycle, s_ar_addr=0x10, 4 beats reach m0, and the 4th beat returns to IDLE.
REQ-033 m0 and m1 request the same cycle (RR on): m0 served first, then m1; repeat both: m0 first again.
REQ-034 Same as REQ-033 with RR off: m0 granted both times while m0 keeps requesting.
REQ-035 m1 requests during m0's len=7 burst: m1_ar_ready stays 0 for all 8 beats, and m1 is granted the cycle after IDLE.
REQ-036 m0 r_ready toggles 0/1 during len=1: s_r_ready mirrors it, and exactly 2 beats are counted.
REQ-037 rst_n pulsed low at beat 2 of a len=3 burst: busy=0 and grant=00 immediately, and the next request is served normally.
